instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : RV32I field-set to instruction-word encoder with a 2-entry
//               output FIFO and delivered-word counter.
//               Optional: define ENC_IMM_CHECK_EN to flag out-of-range
//               immediates as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        out_illegal,
    output logic [15:0] count
);

    localparam logic [6:0]  c_OP_R      = 7'b0110011;
    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;

    logic [31:0] w_word;
    logic        w_bad_op;
    logic        w_flag;
    logic        w_push;
    logic        w_pop;

    logic [32:0] r_mem [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_occ;
    logic [15:0] r_count;

    always_comb begin
        w_word   = c_NOP;
        w_bad_op = 1'b0;
        case (opcode)
            c_OP_R:
                w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            c_OP_IMM: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                else
                    w_word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:
                w_word = {imm[11:0], rs1, funct3, rd, opcode};
            c_OP_STORE:
                w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            c_OP_BRANCH:
                w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            c_OP_LUI, c_OP_AUIPC:
                w_word = {imm[31:12], rd, opcode};
            c_OP_JAL:
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                w_word   = c_NOP;
                w_bad_op = 1'b1;
            end
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;
    logic w_bad_imm;

    // An immediate fits N bits when every bit above N-1 copies bit N-1.
    assign w_fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign w_fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        w_bad_imm = 1'b0;
        case (opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM, c_OP_STORE:
                w_bad_imm = ~w_fits12;
            c_OP_BRANCH:
                w_bad_imm = ~w_fits13 | imm[0];
            c_OP_JAL:
                w_bad_imm = ~w_fits21 | imm[0];
            c_OP_LUI, c_OP_AUIPC:
                w_bad_imm = |imm[11:0];
            default:
                w_bad_imm = 1'b0;
        endcase
    end

    assign w_flag = w_bad_op | w_bad_imm;
`else
    assign w_flag = w_bad_op;
`endif

    assign in_ready    = (r_occ != 2'd2);
    assign out_valid   = (r_occ != 2'd0);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = out_valid & out_ready;
    assign instr       = r_mem[r_rd_ptr][31:0];
    assign out_illegal = r_mem[r_rd_ptr][32];
    assign count       = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_count  <= 16'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_flag, w_word};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_count  <= r_count + 16'd1;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
